// File: rtl/hamming_pkg.sv
// Shared Hamming(21,16) definitions: sizes, parity slot indices, injection FSM states
// and the reference encoder used by both the transmit and the decoder side.
package hamming_pkg;

  localparam int DATA_W = 16;
  localparam int CW_W   = 21;
  localparam int PAR_W  = 5;
  localparam int POS_W  = 5;

  localparam int PAR_IDX [PAR_W] = '{0, 1, 3, 7, 15};
  localparam logic [POS_W-1:0] MAX_POS = POS_W'(CW_W - 1);

  typedef enum logic {
    INJ_IDLE  = 1'b0,
    INJ_ARMED = 1'b1
  } inj_state_e;

  typedef struct packed {
    logic [CW_W-1:0] cw;
    logic            injected;
  } fifo_entry_t;

  // Data bits fill the non-power-of-two positions; parity slots stay zero until the end.
  function automatic logic [CW_W-1:0] hamming_encode(input logic [DATA_W-1:0] data);
    logic [CW_W-1:0]  cw;
    logic [PAR_W-1:0] par;
    cw        = '0;
    cw[2]     = data[15];
    cw[6:4]   = data[14:12];
    cw[14:8]  = data[11:5];
    cw[20:16] = data[4:0];
    par[0] = cw[2] ^ cw[4] ^ cw[6] ^ cw[8] ^ cw[10] ^ cw[12] ^ cw[14] ^ cw[16] ^ cw[18] ^ cw[20];
    par[1] = cw[2] ^ cw[5] ^ cw[6] ^ cw[9] ^ cw[10] ^ cw[13] ^ cw[14] ^ cw[17] ^ cw[18];
    par[2] = cw[4] ^ cw[5] ^ cw[6] ^ cw[11] ^ cw[12] ^ cw[13] ^ cw[14] ^ cw[19] ^ cw[20];
    par[3] = ^cw[14:8];
    par[4] = ^cw[20:16];
    for (int k = 0; k < PAR_W; k++) begin
      cw[PAR_IDX[k]] = par[k];
    end
    return cw;
  endfunction

endpackage

// File: rtl/hamming_encoder_tx_enc_core.sv
// Purely combinational Hamming(21,16) encoder wrapped around the package function.
module hamming_enc_core
  import hamming_pkg::*;
(
  input  logic [DATA_W-1:0] data_i,
  output logic [CW_W-1:0]   cw_o
);

  assign cw_o = hamming_encode(data_i);

endmodule

// File: rtl/hamming_encoder_tx.sv
// Hamming(21,16) transmit encoder: valid/ready input, 2-entry output buffer,
// optional one-shot single-bit error injection and saturating statistics.
module hamming_encoder_tx
  import hamming_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter bit INJ_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [CW_W-1:0]   out_cw,
  output logic              out_injected,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              inj_req,
  input  logic [POS_W-1:0]  inj_pos,
  output logic [CNT_W-1:0]  words_sent,
  output logic [CNT_W-1:0]  words_inj
);

  logic [CW_W-1:0]  enc_cw;
  fifo_entry_t      head_q, head_d, tail_q, tail_d, new_entry;
  logic [1:0]       count_q, count_d;
  inj_state_e       state_q, state_d;
  logic [POS_W-1:0] pos_q, pos_d, flip_pos;
  logic [CNT_W-1:0] sent_q, sent_d, inj_q, inj_d;
  logic             accept, send, req_ok, flip_now;

  hamming_enc_core u_core (
    .data_i (in_data),
    .cw_o   (enc_cw)
  );

  // in_ready depends on registered occupancy only, never on out_ready.
  assign in_ready  = !rst && (count_q != 2'd2);
  assign accept    = in_valid && in_ready;
  assign out_valid = (count_q != 2'd0);
  assign send      = out_valid && out_ready;

  // A request arriving with the word wins over an older armed position.
  assign req_ok   = INJ_EN && inj_req && (inj_pos <= MAX_POS);
  assign flip_now = accept && (req_ok || (state_q == INJ_ARMED));
  assign flip_pos = req_ok ? inj_pos : pos_q;

  always_comb begin
    new_entry.cw       = enc_cw ^ (flip_now ? (CW_W'(1) << flip_pos) : '0);
    new_entry.injected = flip_now;
  end

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    if (flip_now) begin
      state_d = INJ_IDLE;
    end else if (req_ok) begin
      state_d = INJ_ARMED;
      pos_d   = inj_pos;
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    case ({accept, send})
      2'b10: begin
        if (count_q == 2'd0) head_d = new_entry;
        else                 tail_d = new_entry;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      // Simultaneous accept and send only happens with exactly one entry held.
      2'b11: head_d = new_entry;
      default: ;
    endcase
  end

  always_comb begin
    sent_d = sent_q;
    inj_d  = inj_q;
    if (send && (sent_q != '1)) sent_d = sent_q + CNT_W'(1);
    if (send && head_q.injected && (inj_q != '1)) inj_d = inj_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
      state_q <= INJ_IDLE;
      pos_q   <= '0;
      sent_q  <= '0;
      inj_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      state_q <= state_d;
      pos_q   <= pos_d;
      sent_q  <= sent_d;
      inj_q   <= inj_d;
    end
  end

  assign out_cw       = head_q.cw;
  assign out_injected = head_q.injected;
  assign words_sent   = sent_q;
  assign words_inj    = inj_q;

endmodule

// File: tb/tb_hamming_encoder_tx.sv
// Directed bench for hamming_encoder_tx with a position-based reference encoder/decoder
// and an expected-output scoreboard; small counters make saturation reachable.
module tb_hamming_encoder_tx;

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] SAT = '1;
  // Hamming position (1-based) carrying data bit i.
  localparam int POS_TAB [16] = '{17, 18, 19, 20, 21, 9, 10, 11, 12, 13, 14, 15, 5, 6, 7, 3};

  logic        clk;
  logic        rst;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [20:0] out_cw;
  logic        out_injected;
  logic        out_valid;
  logic        out_ready;
  logic        inj_req;
  logic [4:0]  inj_pos;
  logic [CNT_W-1:0] words_sent;
  logic [CNT_W-1:0] words_inj;

  typedef struct {
    logic [20:0] cw;
    logic        inj;
    logic [15:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   stalls = 0;

  hamming_encoder_tx #(.CNT_W(CNT_W), .INJ_EN(1'b1)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_cw       (out_cw),
    .out_injected (out_injected),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .inj_req      (inj_req),
    .inj_pos      (inj_pos),
    .words_sent   (words_sent),
    .words_inj    (words_inj)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [20:0] model_encode(input logic [15:0] d);
    logic [20:0] cw;
    logic        p;
    cw = '0;
    for (int i = 0; i < 16; i++) cw[POS_TAB[i]-1] = d[i];
    for (int k = 0; k < 5; k++) begin
      p = 1'b0;
      for (int pos = 1; pos <= 21; pos++)
        if (((pos >> k) & 1) == 1 && pos != (1 << k)) p = p ^ cw[pos-1];
      cw[(1 << k)-1] = p;
    end
    return cw;
  endfunction

  // Returns {error_seen, corrected data}.
  function automatic logic [16:0] model_decode(input logic [20:0] cw_in);
    logic [20:0] cw;
    logic [15:0] d;
    int          syn;
    cw  = cw_in;
    syn = 0;
    for (int pos = 1; pos <= 21; pos++) if (cw[pos-1]) syn = syn ^ pos;
    if (syn != 0 && syn <= 21) cw[syn-1] = ~cw[syn-1];
    for (int i = 0; i < 16; i++) d[i] = cw[POS_TAB[i]-1];
    return {(syn != 0), d};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_out: got %0h expected no output", out_cw);
      end else begin
        mon_e = sb.pop_front();
        $display("out cw=%06h inj=%0b (exp cw=%06h inj=%0b)", out_cw, out_injected, mon_e.cw, mon_e.inj);
        chk("out_cw", out_cw, mon_e.cw);
        chk("out_injected", out_injected, mon_e.inj);
        chk("loopback", model_decode(out_cw), {mon_e.inj, mon_e.data});
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [15:0] d, input bit req, input logic [4:0] p, input bit exp_flip);
    exp_t e;
    int   n;
    in_data  = d;
    in_valid = 1'b1;
    inj_req  = req;
    inj_pos  = p;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 30) begin
      n++;
      stalls++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $error("FAIL accept_timeout: got in_ready=0 expected 1 for data %0h", d);
    end else begin
      e.data = d;
      e.cw   = model_encode(d) ^ (exp_flip ? (21'd1 << p) : 21'd0);
      e.inj  = exp_flip;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    inj_req  = 1'b0;
  endtask

  task automatic pulse_inj(input logic [4:0] p);
    inj_req = 1'b1;
    inj_pos = p;
    tick();
    inj_req = 1'b0;
  endtask

  task automatic drain;
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    chk("drain", sb.size(), 0);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    sb.delete();
    tick();
    chk("rst_in_ready", in_ready, 1'b0);
    rst = 1'b0;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_cw", out_cw, 21'h0);
    chk("rst_out_inj", out_injected, 1'b0);
    chk("rst_sent", words_sent, 0);
    chk("rst_inj", words_inj, 0);
  endtask

  initial begin
    logic [15:0] rd;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    inj_req   = 1'b0;
    inj_pos   = '0;
    tick();
    do_reset();

    // Latency: visible one cycle after acceptance
    out_ready = 1'b1;
    offer(16'h0000, 1'b0, 5'd0, 1'b0);
    chk("t1_valid", out_valid, 1'b1);
    chk("t1_cw", out_cw, 21'h000000);
    chk("t1_inj", out_injected, 1'b0);
    drain();

    // Back-to-back at full rate
    do_reset();
    out_ready = 1'b1;
    stalls = 0;
    offer(16'hFFFF, 1'b0, 5'd0, 1'b0);
    chk("t2_cw_ffff", out_cw, 21'h1FFFFE);
    offer(16'h8000, 1'b0, 5'd0, 1'b0);
    chk("t2_cw_8000", out_cw, 21'h000007);
    offer(16'h0001, 1'b0, 5'd0, 1'b0);
    chk("t2_cw_0001", out_cw, 21'h018001);
    chk("t2_stalls", stalls, 0);
    drain();
    chk("t2_sent", words_sent, 3);

    // Backpressure: buffer holds two, output stable, order preserved
    out_ready = 1'b0;
    offer(16'h1111, 1'b0, 5'd0, 1'b0);
    offer(16'h2222, 1'b0, 5'd0, 1'b0);
    chk("t3_full_ready", in_ready, 1'b0);
    chk("t3_head", out_cw, model_encode(16'h1111));
    tick();
    tick();
    chk("t3_hold", out_cw, model_encode(16'h1111));
    chk("t3_hold_valid", out_valid, 1'b1);
    out_ready = 1'b1;
    offer(16'h3333, 1'b0, 5'd0, 1'b0);
    drain();

    // Injection at position 5, next word clean
    do_reset();
    out_ready = 1'b1;
    pulse_inj(5'd5);
    offer(16'h0000, 1'b0, 5'd5, 1'b1);
    chk("t4_cw", out_cw, 21'h000020);
    chk("t4_inj", out_injected, 1'b1);
    offer(16'h0000, 1'b0, 5'd0, 1'b0);
    chk("t4_clean", out_injected, 1'b0);
    drain();
    chk("t4_words_inj", words_inj, 1);

    // Out-of-range request ignored, latest position wins, same-cycle request
    pulse_inj(5'd21);
    offer(16'h1234, 1'b0, 5'd0, 1'b0);
    offer(16'h4321, 1'b1, 5'd31, 1'b0);
    pulse_inj(5'd3);
    pulse_inj(5'd9);
    offer(16'hABCD, 1'b0, 5'd9, 1'b1);
    chk("t5_latest_inj", out_injected, 1'b1);
    drain();
    for (int p = 0; p <= 20; p++) begin
      rd = 16'($urandom);
      offer(rd, 1'b1, 5'(p), 1'b1);
    end
    drain();
    chk("t5_sent_sat", words_sent, SAT);
    chk("t5_inj_sat", words_inj, SAT);

    // Reset with two words buffered and injection armed
    out_ready = 1'b0;
    offer(16'h0F0F, 1'b0, 5'd0, 1'b0);
    offer(16'hF0F0, 1'b0, 5'd0, 1'b0);
    pulse_inj(5'd2);
    chk("t6_pre_valid", out_valid, 1'b1);
    do_reset();
    out_ready = 1'b1;
    offer(16'h5555, 1'b0, 5'd0, 1'b0);
    chk("t6_disarmed", out_injected, 1'b0);
    chk("t6_cw", out_cw, model_encode(16'h5555));
    drain();
    chk("t6_sent", words_sent, 1);
    chk("t6_inj", words_inj, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
